// File: rtl/reset_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// reset_pkg: shared types and helpers for the core reset sequencer. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package reset_pkg;

  localparam int RESET_COUNT_W = 8;

  typedef enum logic [1:0] {
    LOCK_WAIT = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2,
    BTN       = 2'd3
  } rst_state_t;

  typedef enum logic [1:0] {
    POWERON   = 2'd0,
    BUTTON    = 2'd1,
    LOCK_LOSS = 2'd2
  } rst_cause_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/reset_sequencer_sync_debounce.sv
// ----------------------------------------------------------------------------
// sync_debounce: multi-flop synchronizer with optional stable-level debounce. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sync_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 80000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout
);

  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_ff <= '0;
    end else begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], din};
    end
  end

  assign sync = sync_ff[SYNC_STAGES-1];

  generate
    if (DEBOUNCE_CYCLES <= 1) begin : g_bypass
      assign dout = sync;
    end else begin : g_debounce
      localparam int DB_W = $clog2(DEBOUNCE_CYCLES) + 1;
      logic [DB_W-1:0] deb_cnt;

      // The output only follows the synchronized level after it has differed for DEBOUNCE_CYCLES.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          deb_cnt <= '0;
          dout    <= 1'b0;
        end else if (sync != dout) begin
          if (deb_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            dout    <= sync;
            deb_cnt <= '0;
          end else begin
            deb_cnt <= deb_cnt + DB_W'(1);
          end
        end else begin
          deb_cnt <= '0;
        end
      end
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/reset_sequencer.sv
// ----------------------------------------------------------------------------
// reset_sequencer: PLL-lock and button qualified core reset generator. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module reset_sequencer
  import reset_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 80000,
  parameter int LOCK_CYCLES     = 16,
  parameter int HOLD_CYCLES     = 16,
  parameter int CNT_W           = $clog2(max3(DEBOUNCE_CYCLES, LOCK_CYCLES, HOLD_CYCLES)) + 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     btn_raw,
  input  logic                     pll_locked,
  output logic                     core_reset_n,
  output logic [1:0]               reset_cause,
  output logic [RESET_COUNT_W-1:0] reset_count,
  output logic                     btn_db
);

  logic       lock_sync;
  rst_state_t state;
  rst_cause_t cause;
  logic [CNT_W-1:0] seq_cnt;

  sync_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk    (clk),
    .reset_n(reset_n),
    .din    (btn_raw),
    .dout   (btn_db)
  );

  sync_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(1)
  ) u_lock (
    .clk    (clk),
    .reset_n(reset_n),
    .din    (pll_locked),
    .dout   (lock_sync)
  );

  assign reset_cause = cause;

  // core_reset_n is loaded with (next state == RUN), so it is high exactly while in RUN.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= LOCK_WAIT;
      cause        <= POWERON;
      seq_cnt      <= '0;
      reset_count  <= '0;
      core_reset_n <= 1'b0;
    end else begin
      core_reset_n <= 1'b0;
      case (state)
        LOCK_WAIT: begin
          if (!lock_sync) begin
            seq_cnt <= '0;
          end else if (seq_cnt == CNT_W'(LOCK_CYCLES - 1)) begin
            state   <= HOLD;
            seq_cnt <= '0;
          end else begin
            seq_cnt <= seq_cnt + CNT_W'(1);
          end
        end
        HOLD: begin
          if (!lock_sync) begin
            state   <= LOCK_WAIT;
            seq_cnt <= '0;
          end else if (seq_cnt == CNT_W'(HOLD_CYCLES - 1)) begin
            state        <= RUN;
            seq_cnt      <= '0;
            core_reset_n <= 1'b1;
          end else begin
            seq_cnt <= seq_cnt + CNT_W'(1);
          end
        end
        RUN: begin
          if (!lock_sync || btn_db) begin
            state <= lock_sync ? BTN : LOCK_WAIT;
            cause <= lock_sync ? BUTTON : LOCK_LOSS;
            if (reset_count != {RESET_COUNT_W{1'b1}}) begin
              reset_count <= reset_count + RESET_COUNT_W'(1);
            end
          end else begin
            core_reset_n <= 1'b1;
          end
        end
        BTN: begin
          if (!lock_sync) begin
            state   <= LOCK_WAIT;
            seq_cnt <= '0;
          end else if (!btn_db) begin
            state   <= HOLD;
            seq_cnt <= '0;
          end
        end
        default: begin
          state   <= LOCK_WAIT;
          seq_cnt <= '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_reset_sequencer.sv
// ----------------------------------------------------------------------------
// tb_reset_sequencer: scoreboard-checked bench for reset_sequencer. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       btn_raw;
  logic       pll_locked;
  logic       core_reset_n;
  logic [1:0] reset_cause;
  logic [7:0] reset_count;
  logic       btn_db;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  typedef struct {
    int         cyc;
    logic       core;
    logic [1:0] cause;
    logic [7:0] count;
    logic       db;
  } exp_t;

  typedef struct {
    int   off;
    logic core;
  } por_t;

  exp_t  sbq[$];
  string nmq[$];
  por_t  por_tbl[10];

  reset_sequencer #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .LOCK_CYCLES    (4),
    .HOLD_CYCLES    (3)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .btn_raw     (btn_raw),
    .pll_locked  (pll_locked),
    .core_reset_n(core_reset_n),
    .reset_cause (reset_cause),
    .reset_count (reset_count),
    .btn_db      (btn_db)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  task automatic check(input string nm, input logic c, input logic [1:0] ca,
                       input logic [7:0] cn, input logic d);
    checks++;
    if (core_reset_n !== c || reset_cause !== ca || reset_count !== cn || btn_db !== d) begin
      errors++;
      $display("FAIL %s @cycle %0d: got core=%b cause=%0d count=%0d db=%b, want core=%b cause=%0d count=%0d db=%b",
               nm, cycle, core_reset_n, reset_cause, reset_count, btn_db, c, ca, cn, d);
    end
  endtask

  task automatic expect_at(input int off, input string nm, input logic c,
                           input logic [1:0] ca, input logic [7:0] cn, input logic d);
    exp_t e;
    e.cyc   = cycle + off;
    e.core  = c;
    e.cause = ca;
    e.count = cn;
    e.db    = d;
    sbq.push_back(e);
    nmq.push_back(nm);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Release reset_n at this negedge and queue the power-on latency profile.
  task automatic release_and_expect_por(input string nm);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      expect_at(por_tbl[i].off, nm, por_tbl[i].core, 2'd0, 8'd0, 1'b0);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t  e;
    string nm;
    while (sbq.size() > 0 && sbq[0].cyc <= cycle) begin
      e  = sbq.pop_front();
      nm = nmq.pop_front();
      check(nm, e.core, e.cause, e.count, e.db);
    end
  end

  initial begin
    int           t0;
    logic [5:0]   bounce;
    logic [7:0]   sat;

    for (int i = 0; i < 10; i++) begin
      por_tbl[i].off  = i + 1;
      por_tbl[i].core = (i >= 8);
    end

    reset_n    = 1'b0;
    btn_raw    = 1'b0;
    pll_locked = 1'b1;
    step(3);
    check("reset_state", 1'b0, 2'd0, 8'd0, 1'b0);

    // Power-on: core_reset_n rises 2+4+3 edges after release.
    release_and_expect_por("poweron");
    step(12);

    // Bounce never stays stable for 4 synchronized cycles.
    bounce = 6'b011011;
    for (int k = 1; k <= 10; k++) expect_at(k, "bounce", 1'b1, 2'd0, 8'd0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      btn_raw = bounce[i];
      step(1);
    end
    step(6);

    // Long press.
    btn_raw = 1'b1;
    expect_at(6,  "press_db_rise",  1'b1, 2'd0, 8'd0, 1'b1);
    expect_at(7,  "press_core_low", 1'b0, 2'd1, 8'd1, 1'b1);
    expect_at(19, "press_held",     1'b0, 2'd1, 8'd1, 1'b1);
    expect_at(26, "release_db_low", 1'b0, 2'd1, 8'd1, 1'b0);
    expect_at(29, "release_hold",   1'b0, 2'd1, 8'd1, 1'b0);
    expect_at(30, "release_run",    1'b1, 2'd1, 8'd1, 1'b0);
    step(20);
    btn_raw = 1'b0;
    step(12);

    // Lock loss for 5 cycles.
    pll_locked = 1'b0;
    expect_at(2,  "lockloss_pre",  1'b1, 2'd1, 8'd1, 1'b0);
    expect_at(3,  "lockloss_low",  1'b0, 2'd2, 8'd2, 1'b0);
    expect_at(13, "relock_hold",   1'b0, 2'd2, 8'd2, 1'b0);
    expect_at(14, "relock_run",    1'b1, 2'd2, 8'd2, 1'b0);
    step(5);
    pll_locked = 1'b1;
    step(12);

    // btn_db rise and lock_sync fall land on the same edge: lock loss wins.
    btn_raw = 1'b1;
    expect_at(6,  "simul_pre",   1'b1, 2'd2, 8'd2, 1'b1);
    expect_at(7,  "simul_exit",  1'b0, 2'd2, 8'd3, 1'b1);
    expect_at(17, "simul_run",   1'b1, 2'd2, 8'd3, 1'b0);
    expect_at(19, "simul_stay",  1'b1, 2'd2, 8'd3, 1'b0);
    step(4);
    pll_locked = 1'b0;
    step(4);
    pll_locked = 1'b1;
    btn_raw    = 1'b0;
    step(14);

    // Saturation of the exit counter.
    for (int i = 0; i < 260; i++) begin
      sat = (4 + i > 255) ? 8'd255 : 8'(4 + i);
      btn_raw = 1'b1;
      expect_at(19, "saturate", 1'b1, 2'd1, sat, 1'b0);
      step(8);
      btn_raw = 1'b0;
      step(12);
    end

    // Async reset pulse in the middle of HOLD.
    t0 = cycle;
    btn_raw = 1'b1;
    expect_at(15, "pre_async_hold", 1'b0, 2'd1, 8'd255, 1'b0);
    step(8);
    btn_raw = 1'b0;
    step(8);
    if (cycle != t0 + 16) begin
      checks++;
      errors++;
      $display("FAIL async_timing: got cycle %0d, want %0d", cycle, t0 + 16);
    end
    #2 reset_n = 1'b0;
    #1 check("async_reset", 1'b0, 2'd0, 8'd0, 1'b0);
    step(1);
    release_and_expect_por("restart");
    step(14);

    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sbq.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
